// File: rtl/ph_collect.sv
// ph_collect: result collector for the hit-parameter path.
// Every ph_vld event is stamped with a 16-bit sequence number and pushed
// into a DEPTH-entry FIFO. The host pops entries through a registered
// request/valid read port.
//
// Ports:
//   clk_sys    system clock
//   rst        asynchronous active-high reset
//   ph_ring    ring count of a completed hit event
//   ph_vld     one-cycle event strobe, ph_ring valid with it
//   cfg_clr    synchronous flush; overrides all other activity in its cycle
//   rd_req     pop request
//   rd_data    popped entry {seq, ring}; holds between pops
//   rd_vld     one-cycle strobe marking new rd_data
//   stu_cnt    fill level 0..DEPTH
//   stu_empty  fill level is zero
//   stu_full   fill level is DEPTH
//   stu_ovf    sticky: at least one event was dropped
//   stu_seq    events seen since reset/flush, dropped ones included
module ph_collect #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic [15:0]   ph_ring,
    input  logic          ph_vld,
    input  logic          cfg_clr,
    input  logic          rd_req,
    output logic [31:0]   rd_data,
    output logic          rd_vld,
    output logic [AW:0]   stu_cnt,
    output logic          stu_empty,
    output logic          stu_full,
    output logic          stu_ovf,
    output logic [15:0]   stu_seq
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [15:0]   seq_q, seq_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          rd_vld_q, rd_vld_d;

    logic          empty;
    logic          full;
    logic          pop;
    logic          wr;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_FULL);

    // A pop at full frees the slot the incoming event needs, so a
    // simultaneous write is accepted rather than dropped.
    assign pop = rd_req && !empty && !cfg_clr;
    assign wr  = ph_vld && (!full || pop) && !cfg_clr;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        seq_d     = seq_q;
        ovf_d     = ovf_q;
        rd_data_d = rd_data_q;
        rd_vld_d  = 1'b0;

        if (cfg_clr) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            seq_d  = '0;
            ovf_d  = 1'b0;
        end else begin
            if (ph_vld) begin
                seq_d = seq_q + 16'd1;
                if (!wr) begin
                    ovf_d = 1'b1;
                end
            end
            if (wr) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d    = rptr_q + AW'(1);
                rd_data_d = mem[rptr_q];
                rd_vld_d  = 1'b1;
            end
            if (wr && !pop) begin
                cnt_d = cnt_q + CNT_ONE;
            end else if (pop && !wr) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    // Storage has no reset; contents are don't-care until written.
    always_ff @(posedge clk_sys) begin
        if (wr) begin
            mem[wptr_q] <= {seq_q, ph_ring};
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            seq_q     <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            seq_q     <= seq_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_vld    = rd_vld_q;
    assign stu_cnt   = cnt_q;
    assign stu_empty = empty;
    assign stu_full  = full;
    assign stu_ovf   = ovf_q;
    assign stu_seq   = seq_q;

endmodule

// File: tb/tb_ph_collect.sv
module tb_ph_collect;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk_sys = 1'b0;
    logic          rst     = 1'b1;
    logic [15:0]   ph_ring = '0;
    logic          ph_vld  = 1'b0;
    logic          cfg_clr = 1'b0;
    logic          rd_req  = 1'b0;
    logic [31:0]   rd_data;
    logic          rd_vld;
    logic [AW:0]   stu_cnt;
    logic          stu_empty;
    logic          stu_full;
    logic          stu_ovf;
    logic [15:0]   stu_seq;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: a plain queue of entries plus the scalar status.
    logic [31:0]   m_q[$];
    logic [15:0]   m_seq;
    bit            m_ovf;
    logic [31:0]   m_data;
    bit            m_vld;

    ph_collect #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .ph_ring   (ph_ring),
        .ph_vld    (ph_vld),
        .cfg_clr   (cfg_clr),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .rd_vld    (rd_vld),
        .stu_cnt   (stu_cnt),
        .stu_empty (stu_empty),
        .stu_full  (stu_full),
        .stu_ovf   (stu_ovf),
        .stu_seq   (stu_seq)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_seq  = '0;
        m_ovf  = 1'b0;
        m_data = '0;
        m_vld  = 1'b0;
    endtask

    task automatic check_all();
        check("rd_vld",    64'(rd_vld),    64'(m_vld));
        check("rd_data",   64'(rd_data),   64'(m_data));
        check("stu_cnt",   64'(stu_cnt),   64'(m_q.size()));
        check("stu_empty", 64'(stu_empty), 64'(m_q.size() == 0));
        check("stu_full",  64'(stu_full),  64'(m_q.size() == DEPTH));
        check("stu_ovf",   64'(stu_ovf),   64'(m_ovf));
        check("stu_seq",   64'(stu_seq),   64'(m_seq));
    endtask

    // One clock cycle: drive, clock, update the model, compare.
    task automatic step(input bit vld, input logic [15:0] ring, input bit req, input bit clr);
        ph_vld  = vld;
        ph_ring = ring;
        rd_req  = req;
        cfg_clr = clr;
        @(posedge clk_sys);
        #1;
        ph_vld  = 1'b0;
        rd_req  = 1'b0;
        cfg_clr = 1'b0;
        if (clr) begin
            m_q.delete();
            m_seq = '0;
            m_ovf = 1'b0;
            m_vld = 1'b0;
        end else begin
            m_vld = 1'b0;
            if (req && m_q.size() > 0) begin
                m_data = m_q.pop_front();
                m_vld  = 1'b1;
            end
            if (vld) begin
                if (m_q.size() < DEPTH) m_q.push_back({m_seq, ring});
                else                    m_ovf = 1'b1;
                m_seq = m_seq + 16'd1;
            end
        end
        check_all();
    endtask

    task automatic flush();
        step(1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(posedge clk_sys);
        #1 rst = 1'b0;
        check_all();

        // Three events then three pops.
        step(1'b1, 16'h0010, 1'b0, 1'b0);
        step(1'b1, 16'h0020, 1'b0, 1'b0);
        step(1'b1, 16'h0030, 1'b0, 1'b0);
        check("cnt_after3", 64'(stu_cnt), 64'd3);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        check("pop0", 64'(rd_data), 64'h0000_0010);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        check("pop1", 64'(rd_data), 64'h0001_0020);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        check("pop2", 64'(rd_data), 64'h0002_0030);
        check("empty_after3", 64'(stu_empty), 64'd1);

        // Pop while empty: no strobe, data held.
        step(1'b0, 16'h0, 1'b1, 1'b0);
        check("empty_pop_vld",  64'(rd_vld),  64'd0);
        check("empty_pop_data", 64'(rd_data), 64'h0002_0030);

        // 17 events, no reads: last one dropped.
        flush();
        for (int i = 0; i < 17; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
        check("ovf_full", 64'(stu_full), 64'd1);
        check("ovf_flag", 64'(stu_ovf),  64'd1);
        check("ovf_seq",  64'(stu_seq),  64'd17);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0);
            check("ovf_pop_seq", 64'(rd_data[31:16]), 64'(i));
        end

        // Five entries, ovf set: flush together with vld and req.
        check("pre_clr_cnt", 64'(stu_cnt), 64'd4);
        step(1'b1, 16'hAAAA, 1'b0, 1'b0);
        check("pre_clr_cnt5", 64'(stu_cnt), 64'd5);
        step(1'b1, 16'hBBBB, 1'b1, 1'b1);
        check("clr_cnt", 64'(stu_cnt), 64'd0);
        check("clr_ovf", 64'(stu_ovf), 64'd0);
        check("clr_seq", 64'(stu_seq), 64'd0);
        check("clr_vld", 64'(rd_vld),  64'd0);

        // Full plus simultaneous write and pop.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
        step(1'b1, 16'h0F0F, 1'b1, 1'b0);
        check("fullrw_ovf", 64'(stu_ovf), 64'd0);
        check("fullrw_cnt", 64'(stu_cnt), 64'd16);
        check("fullrw_pop", 64'(rd_data), 64'h0000_0200);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        check("fullrw_last", 64'(rd_data), 64'h0010_0F0F);

        // One entry: write and pop together.
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        step(1'b1, 16'h5678, 1'b1, 1'b0);
        check("one_rw_cnt", 64'(stu_cnt), 64'd1);

        // Asynchronous reset mid-operation.
        step(1'b1, 16'h9999, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk_sys);
        #1 rst = 1'b0;
        check_all();

        // Randomized traffic with varying write/read pressure.
        for (int seg = 0; seg < 12; seg++) begin
            int pw = $urandom_range(10, 90);
            int pr = $urandom_range(10, 90);
            for (int i = 0; i < 150; i++) begin
                step($urandom_range(99) < pw, 16'($urandom), $urandom_range(99) < pr,
                     $urandom_range(199) == 0);
            end
        end

        // Sequence wrap: 65537 events with concurrent pops.
        flush();
        step(1'b1, 16'h0000, 1'b0, 1'b0);
        for (int i = 1; i < 65537; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
        check("wrap_seq", 64'(stu_seq), 64'h0001);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        check("wrap_last_seq", 64'(rd_data[31:16]), 64'h0000);
        check("wrap_empty", 64'(stu_empty), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ph_collect.md
# ph_collect

Result collector at the downstream end of the hit-parameter path. It captures each `ph_ring`/`ph_vld` event produced by the hit-parameter extractor. Each event is tagged with a 16-bit sequence number and buffered in a small FIFO. The host register side pops entries through a request/valid read port. Status outputs report fill level, full/empty and a sticky overflow flag.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 4..256.
- `AW`, 4: pointer width; must equal log2(`DEPTH`).

Ports:
- `clk_sys`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `ph_ring`  in  16  ring count of a completed hit event.
- `ph_vld`  in  1  one-cycle strobe; `ph_ring` is valid in the same cycle.
- `cfg_clr`  in  1  synchronous flush pulse from the register block.
- `rd_req`  in  1  pop request, one cycle per pop.
- `rd_data`  out  32  popped entry: {seq[15:0], ring[15:0]}.
- `rd_vld`  out  1  one-cycle strobe marking new `rd_data`.
- `stu_cnt`  out  AW+1  current fill level, 0..DEPTH.
- `stu_empty`  out  1  high when `stu_cnt` == 0.
- `stu_full`  out  1  high when `stu_cnt` == DEPTH.
- `stu_ovf`  out  1  sticky flag: an event was dropped.
- `stu_seq`  out  16  total events seen, including dropped ones; wraps.

## Operation
- Sequence counter `seq`:
  - On every `ph_vld`, the entry written is {`seq`, `ph_ring`}.
  - `seq` then increments by 1, modulo 2^16 (0xFFFF -> 0x0000).
  - `seq` increments even when the event is dropped.
  - `stu_seq` equals `seq`.
- Write:
  - Accepted when `ph_vld` is high and the FIFO is not full, or it is full and a pop is accepted in the same cycle.
  - An accepted write stores at `wptr`; `wptr` then increments modulo DEPTH.
- Drop: `ph_vld` while full with no pop in the same cycle. The entry is discarded and `stu_ovf` is set to 1.
- Read:
  - `rd_req` while not empty is an accepted pop.
  - On the next cycle `rd_data` shows the entry at `rptr` and `rd_vld` is high for one cycle.
  - `rptr` increments modulo DEPTH.
- `rd_req` while empty is ignored: no `rd_vld`, `rd_data` unchanged.
- `rd_data` holds its last value between pops.
- Fill level `stu_cnt`:
  - +1 on a write alone, -1 on a pop alone.
  - Unchanged on a write and pop in the same cycle; this holds both when empty-to-be and at full.
- Simultaneous write and pop when the FIFO holds one entry: the pop returns the old entry and the new entry remains.
- `cfg_clr` has priority over every other operation in its cycle:
  - `wptr`, `rptr`, `stu_cnt`, `seq` and `stu_ovf` return to 0.
  - A `ph_vld` in the same cycle is neither stored nor counted.
  - An `rd_req` in the same cycle is ignored.
  - `rd_data` is retained.
- `stu_ovf` is cleared only by `cfg_clr` or `rst`.

## Timing
- Reset values:
  - `rd_data` = 0, `rd_vld` = 0.
  - `stu_cnt` = 0, `stu_empty` = 1, `stu_full` = 0.
  - `stu_ovf` = 0, `stu_seq` = 0.
  - Pointers = 0; storage contents don't-care.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. Operation resumes on the first `clk_sys` edge after `rst` deasserts.
- Write latency: the entry becomes poppable on the cycle after `ph_vld`. `stu_cnt`, `stu_empty` and `stu_full` update on that same edge.
- Read latency:
  - `rd_req` in cycle N gives `rd_vld` and `rd_data` in cycle N+1, both registered.
  - Back-to-back `rd_req` gives one entry per cycle.
- Status outputs are registered and reflect the state after the last edge.
- Throughput: one write and one pop per cycle, sustained.
- Storage is a register array or inferred RAM with synchronous read; no combinational path from `rd_req` to `rd_data`.

## Test plan
- Reset, then 3 `ph_vld` events with ring 0x0010, 0x0020, 0x0030, then 3 `rd_req`:
  - `rd_data` = 0x00000010, 0x00010020, 0x00020030.
  - `stu_cnt` goes 3 -> 0; `stu_empty` = 1.
- 17 `ph_vld` events with no reads (DEPTH=16):
  - `stu_full` = 1, `stu_ovf` = 1, `stu_seq` = 17.
  - 16 pops return seq 0..15; the 17th event is absent.
- FIFO full and `ph_vld` with `rd_req` in the same cycle:
  - No overflow; `stu_cnt` stays 16.
  - Pop returns the oldest entry; the new entry is read last.
- `rd_req` while empty: `rd_vld` stays 0 and `rd_data` holds its previous value.
- `cfg_clr` asserted together with `ph_vld` and `rd_req` on a FIFO with 5 entries and `stu_ovf` = 1:
  - Next cycle `stu_cnt` = 0, `stu_ovf` = 0, `stu_seq` = 0, `rd_vld` = 0.
- 65537 events with concurrent pops: `stu_seq` wraps to 0x0001, and the last popped seq field = 0x0000.
